mem_subblock_sched: RTL and testbench

Round-robin command scheduler that shares the single command port of the memory subblock between `NUM_REQ` requesters. It accepts one command per requester, grants one transaction at a time, and forwards the winning command to the memory side. It holds the grant until the memory side reports completion or a watchdog expires, then returns a per-requester done or error pulse. It sits between the datapath masters and `mem_subblock_wrapper` in the `aclk` domain.

---
 rtl/mem_subblock_sched.sv | 142 ++++++++++++++
 tb/tb_mem_subblock_sched.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_subblock_sched.sv
// Round-robin command scheduler for the memory subblock command port.
// One transaction outstanding at a time, with a WAIT-state watchdog.
module mem_subblock_sched #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  input  logic [NUM_REQ-1:0]          req_we,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [NUM_REQ-1:0]          req_err,
  output logic                        m_cmd_valid,
  input  logic                        m_cmd_ready,
  output logic [ADDR_W-1:0]           m_cmd_addr,
  output logic [LEN_W-1:0]            m_cmd_len,
  output logic                        m_cmd_we,
  input  logic                        m_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit WD_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TERM =
    (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  wd_cnt;

  logic              any_req;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   nxt_ptr;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;
  logic              win_we;

  // Round-robin pick: first valid requester starting at rr_ptr.
  always_comb begin
    int j;
    logic [ID_W-1:0] idx;
    any_req = 1'b0;
    win     = '0;
    j       = 0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = ID_W'(j);
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  // Winner payload and the pointer value that follows it.
  always_comb begin
    nxt_ptr  = (win == LAST_ID) ? '0 : win + 1'b1;
    win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
    win_len  = req_len[int'(win)*LEN_W +: LEN_W];
    win_we   = req_we[win];
  end

  // Ready follows the memory side only for the granted requester.
  always_comb begin
    req_ready = '0;
    if (state == S_CMD) req_ready[gnt_id] = m_cmd_ready;
  end

  // Scheduler FSM with registered command and response outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      gnt_id      <= '0;
      wd_cnt      <= '0;
      m_cmd_valid <= 1'b0;
      m_cmd_addr  <= '0;
      m_cmd_len   <= '0;
      m_cmd_we    <= 1'b0;
      req_done    <= '0;
      req_err     <= '0;
      busy        <= 1'b0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            state       <= S_CMD;
            gnt_id      <= win;
            rr_ptr      <= nxt_ptr;
            m_cmd_valid <= 1'b1;
            m_cmd_addr  <= win_addr;
            m_cmd_len   <= win_len;
            m_cmd_we    <= win_we;
            busy        <= 1'b1;
          end
        end
        S_CMD: begin
          if (m_cmd_ready) begin
            state       <= S_WAIT;
            m_cmd_valid <= 1'b0;
            wd_cnt      <= '0;
          end
        end
        S_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (m_done) begin
            req_done[gnt_id] <= 1'b1;
            state            <= S_IDLE;
            busy             <= 1'b0;
          end else if (WD_EN && wd_cnt == TERM) begin
            req_err[gnt_id] <= 1'b1;
            state           <= S_IDLE;
            busy            <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_subblock_sched.sv
// Scoreboard bench for mem_subblock_sched: two requesters,
// watchdog of 16 cycles.
module tb_mem_subblock_sched;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int TO = 16;
  localparam int IW = $clog2(N);

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_we;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_err;
  logic            m_cmd_valid;
  logic            m_cmd_ready;
  logic [AW-1:0]   m_cmd_addr;
  logic [LW-1:0]   m_cmd_len;
  logic            m_cmd_we;
  logic            m_done;
  logic            busy;
  logic [IW-1:0]   gnt_id;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          we;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_subblock_sched #(
    .NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYC(TO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_we(req_we),
    .req_done(req_done), .req_err(req_err),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len),
    .m_cmd_we(m_cmd_we), .m_done(m_done),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 aclk = ~aclk;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [LW-1:0] l, input logic w);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
    req_we[i]            = w;
  endtask

  task automatic expect_cmd(input int i);
    cmd_t c;
    c.id   = i;
    c.addr = req_addr[i*AW +: AW];
    c.len  = req_len[i*LW +: LW];
    c.we   = req_we[i];
    exp_q.push_back(c);
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < lim; n++) begin
      if (m_cmd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_reset;
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    areset      = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_len     = '0;
    req_we      = '0;
    m_cmd_ready = 1'b0;
    m_done      = 1'b0;
    tick();
    tick();
    checks++;
    if (m_cmd_valid !== 1'b0 || m_cmd_addr !== '0 ||
        m_cmd_len !== '0 || m_cmd_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd: got v=%b a=%h l=%h w=%b, want 0",
               m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_we);
    end
    checks++;
    if (req_ready !== '0 || req_done !== '0 || req_err !== '0) begin
      errors++;
      $display("FAIL reset_req: got rdy=%b done=%b err=%b, want 0",
               req_ready, req_done, req_err);
    end
    checks++;
    if (busy !== 1'b0 || gnt_id !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b gnt=%0d, want 0/0",
               busy, gnt_id);
    end
    areset = 1'b0;
    tick();
  endtask

  task automatic test_single;
    cmd_t c;
    bit   bad;
    set_req(0, 32'h1000, 8'd7, 1'b1);
    expect_cmd(0);
    m_cmd_ready  = 1'b1;
    req_valid[0] = 1'b1;
    tick();
    checks++;
    if (m_cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got valid=%b, want 1", m_cmd_valid);
    end
    c = exp_q.pop_front();
    checks++;
    if (m_cmd_addr !== c.addr || m_cmd_len !== c.len ||
        m_cmd_we !== c.we || gnt_id !== IW'(c.id)) begin
      errors++;
      $display("FAIL single_cmd: got id=%0d a=%h l=%0d w=%b, want id=%0d a=%h l=%0d w=%b",
               gnt_id, m_cmd_addr, m_cmd_len, m_cmd_we,
               c.id, c.addr, c.len, c.we);
    end
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b, want 01", req_ready);
    end
    req_valid[0] = 1'b0;
    tick();
    checks++;
    if (m_cmd_valid !== 1'b0 || req_ready !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: got v=%b rdy=%b busy=%b, want 0/00/1",
               m_cmd_valid, req_ready, busy);
    end
    bad = 1'b0;
    for (int n = 0; n < 9; n++) begin
      tick();
      if (req_done !== '0 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL single_wait: got early done/idle, want busy wait");
    end
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    checks++;
    if (req_done !== 2'b01 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got done=%b busy=%b, want 01/0",
               req_done, busy);
    end
    tick();
    checks++;
    if (req_done !== '0) begin
      errors++;
      $display("FAIL single_done_width: got %b, want 00", req_done);
    end
  endtask

  task automatic test_contention;
    cmd_t c;
    bit   ok;
    int   prev;
    pulse_reset();
    set_req(0, 32'hA000_0000, 8'd3, 1'b0);
    set_req(1, 32'hB000_0000, 8'd15, 1'b1);
    for (int t = 0; t < 8; t++) expect_cmd(t % 2);
    m_cmd_ready = 1'b1;
    req_valid   = 2'b11;
    prev        = -1;
    for (int t = 0; t < 8; t++) begin
      wait_valid(10, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL contention_grant%0d: got no valid, want valid", t);
        break;
      end
      c = exp_q.pop_front();
      checks++;
      if (gnt_id !== IW'(c.id) || m_cmd_addr !== c.addr ||
          m_cmd_len !== c.len || m_cmd_we !== c.we) begin
        errors++;
        $display("FAIL contention_cmd%0d: got id=%0d a=%h, want id=%0d a=%h",
                 t, gnt_id, m_cmd_addr, c.id, c.addr);
      end
      checks++;
      if (int'(gnt_id) == prev) begin
        errors++;
        $display("FAIL contention_repeat%0d: got id=%0d twice, want alternation",
                 t, gnt_id);
      end
      checks++;
      if (req_ready !== N'(1 << c.id)) begin
        errors++;
        $display("FAIL contention_ready%0d: got %b, want %b",
                 t, req_ready, N'(1 << c.id));
      end
      prev = int'(gnt_id);
      tick();
      tick();
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      checks++;
      if (req_done !== N'(1 << c.id)) begin
        errors++;
        $display("FAIL contention_done%0d: got %b, want %b",
                 t, req_done, N'(1 << c.id));
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure;
    cmd_t c;
    bit   ok;
    m_cmd_ready = 1'b0;
    set_req(0, 32'h2000, 8'd1, 1'b0);
    expect_cmd(0);
    req_valid = 2'b01;
    wait_valid(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_grant: got no valid, want valid");
    end
    c = exp_q.pop_front();
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (m_cmd_valid !== 1'b1 || m_cmd_addr !== c.addr ||
          m_cmd_len !== c.len || m_cmd_we !== c.we ||
          gnt_id !== IW'(c.id) || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b a=%h rdy=%b, want 1 a=%h rdy=00",
                 n, m_cmd_valid, m_cmd_addr, req_ready, c.addr);
      end
      tick();
    end
    m_cmd_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01 || m_cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready: got rdy=%b v=%b, want 01/1",
               req_ready, m_cmd_valid);
    end
    req_valid = '0;
    tick();
    checks++;
    if (m_cmd_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: got v=%b busy=%b, want 0/1",
               m_cmd_valid, busy);
    end
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    checks++;
    if (req_done !== 2'b01) begin
      errors++;
      $display("FAIL bp_done: got %b, want 01", req_done);
    end
    tick();
  endtask

  task automatic test_watchdog;
    cmd_t c;
    bit   ok;
    bit   seen_done;
    int   cyc;
    set_req(1, 32'h3000, 8'd0, 1'b1);
    expect_cmd(1);
    m_cmd_ready = 1'b1;
    req_valid   = 2'b10;
    wait_valid(10, ok);
    c = exp_q.pop_front();
    checks++;
    if (!ok || gnt_id !== IW'(c.id) || m_cmd_addr !== c.addr) begin
      errors++;
      $display("FAIL wd_grant: got v=%b id=%0d a=%h, want 1 id=%0d a=%h",
               m_cmd_valid, gnt_id, m_cmd_addr, c.id, c.addr);
    end
    req_valid = '0;
    tick();
    cyc       = -1;
    seen_done = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (req_done !== '0) seen_done = 1'b1;
      if (req_err !== '0) begin
        cyc = n;
        break;
      end
    end
    checks++;
    if (cyc != TO) begin
      errors++;
      $display("FAIL wd_latency: got %0d cycles, want %0d", cyc, TO);
    end
    checks++;
    if (req_err !== 2'b10 || busy !== 1'b0 || seen_done) begin
      errors++;
      $display("FAIL wd_err: got err=%b busy=%b done_seen=%b, want 10/0/0",
               req_err, busy, seen_done);
    end
    set_req(0, 32'h4000, 8'd2, 1'b0);
    expect_cmd(0);
    req_valid = 2'b01;
    tick();
    checks++;
    if (req_err !== '0) begin
      errors++;
      $display("FAIL wd_err_width: got %b, want 00", req_err);
    end
    wait_valid(10, ok);
    c = exp_q.pop_front();
    checks++;
    if (!ok || gnt_id !== IW'(c.id) || m_cmd_addr !== c.addr) begin
      errors++;
      $display("FAIL wd_next_grant: got v=%b id=%0d a=%h, want 1 id=%0d a=%h",
               m_cmd_valid, gnt_id, m_cmd_addr, c.id, c.addr);
    end
    req_valid = '0;
    tick();
    tick();
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    checks++;
    if (req_done !== 2'b01) begin
      errors++;
      $display("FAIL wd_next_done: got %b, want 01", req_done);
    end
    tick();
  endtask

  task automatic test_collision;
    cmd_t c;
    bit   ok;
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    checks++;
    if (req_done !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_done_ignored: got done=%b busy=%b, want 00/0",
               req_done, busy);
    end
    set_req(0, 32'h5000, 8'd4, 1'b1);
    expect_cmd(0);
    m_cmd_ready = 1'b1;
    req_valid   = 2'b01;
    wait_valid(10, ok);
    c = exp_q.pop_front();
    checks++;
    if (!ok || gnt_id !== IW'(c.id) || m_cmd_len !== c.len) begin
      errors++;
      $display("FAIL coll_grant: got v=%b id=%0d l=%0d, want 1 id=%0d l=%0d",
               m_cmd_valid, gnt_id, m_cmd_len, c.id, c.len);
    end
    req_valid = '0;
    tick();
    for (int n = 0; n < TO - 1; n++) tick();
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    checks++;
    if (req_done !== 2'b01 || req_err !== '0) begin
      errors++;
      $display("FAIL coll_done: got done=%b err=%b, want 01/00",
               req_done, req_err);
    end
    tick();
    checks++;
    if (req_done !== '0 || req_err !== '0) begin
      errors++;
      $display("FAIL coll_after: got done=%b err=%b, want 00/00",
               req_done, req_err);
    end
  endtask

  task automatic test_reset_mid;
    cmd_t c;
    bit   ok;
    set_req(1, 32'h6000, 8'd5, 1'b0);
    m_cmd_ready = 1'b1;
    req_valid   = 2'b10;
    wait_valid(10, ok);
    req_valid = '0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || gnt_id !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got busy=%b id=%0d, want 1/1",
               busy, gnt_id);
    end
    areset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || m_cmd_valid !== 1'b0 || req_ready !== '0 ||
        req_done !== '0 || req_err !== '0 || gnt_id !== '0 ||
        m_cmd_addr !== '0 || m_cmd_len !== '0 || m_cmd_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got busy=%b v=%b id=%0d a=%h, want all 0",
               busy, m_cmd_valid, gnt_id, m_cmd_addr);
    end
    tick();
    tick();
    set_req(0, 32'h7000, 8'd6, 1'b1);
    expect_cmd(0);
    req_valid = 2'b11;
    areset    = 1'b0;
    wait_valid(10, ok);
    c = exp_q.pop_front();
    checks++;
    if (!ok || gnt_id !== IW'(c.id) || m_cmd_addr !== c.addr ||
        m_cmd_we !== c.we) begin
      errors++;
      $display("FAIL rst_mid_first: got v=%b id=%0d a=%h, want 1 id=%0d a=%h",
               m_cmd_valid, gnt_id, m_cmd_addr, c.id, c.addr);
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_watchdog();
    test_collision();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench time limit");
  end

endmodule
